// File: rtl/param_register_if.sv
// Bus-side bundle for param_register: command strobes and bus data in, register contents and status out.
// Passing this as one port keeps the register's instantiation compact.
interface param_register_if #(
    parameter int WIDTH     = 8,
    parameter int BUS_WIDTH = 16,
    parameter int ERR_CNT_W = 4
);
    logic                 load;
    logic                 clr;
    logic                 inc;
    logic                 dec;
    logic                 shl;
    logic                 shr;
    logic                 ser_in;
    logic                 err_clr;
    logic [BUS_WIDTH-1:0] in_data;
    logic [WIDTH-1:0]     out_data;
    logic                 carry_out;
    logic                 zero;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output load, clr, inc, dec, shl, shr, ser_in, err_clr, in_data,
        input  out_data, carry_out, zero, err, err_cnt
    );

    modport slave (
        input  load, clr, inc, dec, shl, shr, ser_in, err_clr, in_data,
        output out_data, carry_out, zero, err, err_cnt
    );
endinterface

// File: rtl/param_register.sv
// General-purpose datapath register with load/clear/inc/dec, carry/zero status and illegal-command tracking.
// Define BASCOMP_REG_SHIFT_EN to enable the serial shl/shr commands; otherwise those inputs are ignored.
module param_register #(
    parameter int               WIDTH     = 8,
    parameter int               BUS_WIDTH = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               ERR_CNT_W = 4
) (
    input logic             clk,
    input logic             reset,
    param_register_if.slave bus
);
    typedef enum logic [2:0] {
        OP_HOLD, OP_LOAD, OP_CLR, OP_INC, OP_DEC, OP_SHL, OP_SHR, OP_FAULT
    } op_e;

    localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    logic [WIDTH-1:0]     data_q;
    logic                 carry_q;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] cnt_q;
    logic [5:0]           cmd;
    op_e                  op;
    logic                 unused_inputs;

    // Shift strobes only take part in decoding when the shift feature is built in.
`ifdef BASCOMP_REG_SHIFT_EN
    assign cmd = {bus.load, bus.clr, bus.inc, bus.dec, bus.shl, bus.shr};
`else
    assign cmd = {bus.load, bus.clr, bus.inc, bus.dec, 2'b00};
`endif

    assign unused_inputs = ^{bus.in_data, bus.shl, bus.shr, bus.ser_in};

    // NOTE: op gets a default before any branch so this block never infers a latch.
    always_comb begin
        op = OP_HOLD;
        if (!$onehot0(cmd)) op = OP_FAULT;
        else if (cmd[5])    op = OP_LOAD;
        else if (cmd[4])    op = OP_CLR;
        else if (cmd[3])    op = OP_INC;
        else if (cmd[2])    op = OP_DEC;
        else if (cmd[1])    op = OP_SHL;
        else if (cmd[0])    op = OP_SHR;
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= RESET_VAL;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (op == OP_FAULT) begin
            // A fresh error outranks a simultaneous err_clr: the count restarts at one.
            err_q <= 1'b1;
            if (bus.err_clr)      cnt_q <= CNT_ONE;
            else if (cnt_q != '1) cnt_q <= cnt_q + CNT_ONE;
        end else begin
            if (bus.err_clr) begin
                err_q <= 1'b0;
                cnt_q <= '0;
            end
            case (op)
                OP_LOAD: data_q <= bus.in_data[WIDTH-1:0];
                OP_CLR: begin
                    data_q  <= '0;
                    carry_q <= 1'b0;
                end
                OP_INC: begin
                    data_q  <= data_q + ONE;
                    carry_q <= (data_q == '1);
                end
                OP_DEC: begin
                    data_q  <= data_q - ONE;
                    carry_q <= (data_q == '0);
                end
`ifdef BASCOMP_REG_SHIFT_EN
                OP_SHL: begin
                    data_q  <= {data_q[WIDTH-2:0], bus.ser_in};
                    carry_q <= data_q[WIDTH-1];
                end
                OP_SHR: begin
                    data_q  <= {bus.ser_in, data_q[WIDTH-1:1]};
                    carry_q <= data_q[0];
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.out_data  = data_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = (data_q == '0);
    assign bus.err       = err_q;
    assign bus.err_cnt   = cnt_q;
endmodule
